lzc_share_arb: RTL and testbench
================================

# lzc_share_arb

Shared leading-zero/leading-one count unit serving `N_REQ` requesters through one `leading_zero_cnt` instance. Round-robin arbitration picks one request per cycle. A two-stage valid/ready pipeline returns the count tagged with the requester ID. It sits between normalisation clients (FP adders, priority encoders, CLZ/CLO instructions) and the single count datapath they share.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `WI_SZ`, 32: operand width, power of two, ≥2.
- `WO_SZ`, `$clog2(WI_SZ)+1`: count width, covering 0..`WI_SZ`.
- `ID_W`, `$clog2(N_REQ)`: requester ID width.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_ready`  out  `N_REQ`  per-requester accept; at most one bit high per cycle.
- `req_data`  in  `N_REQ*WI_SZ`  operands; requester i uses `[i*WI_SZ +: WI_SZ]`.
- `req_clo`  in  `N_REQ`  1 = count leading ones, 0 = count leading zeros.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  downstream accept.
- `rsp_id`  out  `ID_W`  requester index that owns the result.
- `rsp_cnt`  out  `WO_SZ`  count, 0..`WI_SZ`.
- `rsp_clo`  out  1  mode flag echoed from the request.
- `rsp_all`  out  1  high when `rsp_cnt == WI_SZ`.
- `busy`  out  1  high when either pipeline stage holds an entry.

## Operation
- **Arbitration:** round-robin pointer `ptr`, `ID_W` bits, reset value 0.
  - Search order: `ptr`, `ptr+1`, … mod `N_REQ`. The first requester with `req_valid` high wins.
  - `req_ready[i]` = (i is the winner) & `adv1`.
  - On accept from i: `ptr <= (i+1) mod N_REQ`. With no accept, `ptr` holds.
  - `req_ready` may depend on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Stage 1 (S1):** registers the operand, ID and clo flag, plus the valid bit `v1`.
  - Operand stored pre-conditioned: `~data` when clo=1, `data` otherwise.
- **Count:** combinational `leading_zero_cnt` on the S1 operand, counting from the MSB.
  - All-zero conditioned operand gives `WI_SZ`.
- **Stage 2 (S2):** output registers `rsp_*`, loaded from S1 and the count.
  - `rsp_all` is registered alongside the count; it is not recomputed combinationally.
- **Flow control, with one global stall:**
  - `adv2 = !rsp_valid | rsp_ready`
  - `adv1 = !v1 | adv2`
  - S1 loads when `adv1`; `v1 <=` accept.
  - S2 loads when `adv2`; `rsp_valid <= v1`.
- While `rsp_valid & !rsp_ready`, all `rsp_*` outputs hold stable.
- `busy = v1 | rsp_valid`.
- No entry is ever dropped or duplicated outside reset.

## Timing
- **Reset:** while `rst` is high at a clock edge:
  - `ptr`, `v1`, `rsp_valid`, `rsp_id`, `rsp_cnt`, `rsp_clo`, `rsp_all` all clear to 0.
  - `req_ready` is forced to all-0 while `rst` is high.
  - `busy` reads 0 after the edge.
- **Reset mid-operation:** in-flight S1/S2 entries are discarded and never emerge. Arbitration restarts from requester 0 on the first cycle after `rst` falls.
- **Latency:** a request accepted in cycle c (handshake at the end of c) appears with `rsp_valid=1` in cycle c+2.
- **Throughput:** one result per cycle while `rsp_ready` stays high.
- **Pipeline capacity:** 2 entries.
  - With `rsp_ready` low and both stages full, `req_ready` is all-0.
  - After `rsp_ready` rises, `req_ready` can assert in that same cycle because `adv1` goes high. This means the pipeline does not lose a bubble on release.
- **Simultaneous output drain and S1 refill:** allowed in the same cycle.
- **Pointer wrap:** a grant to index `N_REQ-1` sets `ptr = 0`.

## Test plan
- **Single clz request** (N_REQ=4, WI_SZ=32): req0 `0x0000_FFFF`, clo=0, accepted in cycle 5 → cycle 7 shows `rsp_valid=1`, `rsp_id=0`, `rsp_cnt=16`, `rsp_all=0`.
- **Mode and edge values:**
  - clo `0xF000_0000` → 4.
  - clz `0x0000_0000` → 32, `rsp_all=1`.
  - clo `0xFFFF_FFFF` → 32, `rsp_all=1`.
  - clz `0x8000_0000` → 0.
  - clo `0x7FFF_FFFF` → 0.
- **Fairness:** all four `req_valid` held high, `rsp_ready=1` → grants 0,1,2,3,0,1,…, one per cycle, and `rsp_id` follows the same order 2 cycles later.
- **Pointer skip and wrap:** `ptr=2`, only req1 and req3 valid → grant 3, then 1, then 3.
- **Backpressure:** stream from req2 with `rsp_ready` low for 3 cycles:
  - `rsp_*` stays stable during the stall.
  - `req_ready` drops once 2 entries are held.
  - After release, the results come out in order with no loss or duplicate, checked by the scoreboard.
- **Reset mid-operation:** with 2 entries in flight, pulse `rst` for 1 cycle → the next cycle shows all outputs 0 and `busy=0`, no stale result ever appears, and the first post-reset grant goes to the lowest-indexed valid requester.

Source files
------------

// File: rtl/lzc_share_arb_if.sv
// Request/response bundle for the shared leading-zero/one count unit.
// The master side is the client pool plus the downstream consumer.
// The slave side is the shared count unit.
interface lzc_share_arb_if #(
  parameter int N_REQ = 4,
  parameter int WI_SZ = 32,
  parameter int WO_SZ = $clog2(WI_SZ) + 1,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WI_SZ-1:0] req_data;
  logic [N_REQ-1:0]       req_clo;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WO_SZ-1:0]       rsp_cnt;
  logic                   rsp_clo;
  logic                   rsp_all;
  logic                   busy;

  modport master (
    output req_valid, req_data, req_clo, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_cnt, rsp_clo, rsp_all, busy
  );

  modport slave (
    input  req_valid, req_data, req_clo, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_cnt, rsp_clo, rsp_all, busy
  );
endinterface

// File: rtl/lzc_share_arb.sv
// Shared leading-zero/one count unit: round-robin arbitration over N_REQ
// requesters feeding one leading_zero_cnt through a two-stage valid/ready
// pipeline. Results come back tagged with the requester index.

// Combinational leading-zero count from the MSB; an all-zero input gives WI_SZ.
module leading_zero_cnt #(
  parameter int WI_SZ = 32,
  parameter int WO_SZ = $clog2(WI_SZ) + 1
) (
  input  logic [WI_SZ-1:0] data,
  output logic [WO_SZ-1:0] cnt
);
  // Scan LSB to MSB so the highest set bit writes last and wins.
  always_comb begin
    // NOTE: default assigned first so every path drives cnt and no latch is inferred.
    cnt = WO_SZ'(WI_SZ);
    for (int i = 0; i < WI_SZ; i++) begin
      if (data[i]) cnt = WO_SZ'(WI_SZ - 1 - i);
    end
  end
endmodule

module lzc_share_arb #(
  parameter int N_REQ = 4,
  parameter int WI_SZ = 32,
  parameter int WO_SZ = $clog2(WI_SZ) + 1,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic          clk,
  input logic          rst,
  lzc_share_arb_if.slave bus
);

  // Arbitration state and decision.
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win;
  logic             found;
  logic             accept;

  // Stage 1: pre-conditioned operand so one zero counter serves both modes.
  logic             v1;
  logic [WI_SZ-1:0] op1;
  logic [ID_W-1:0]  id1;
  logic             clo1;

  // Stage 2: response registers.
  logic             rsp_valid;
  logic [ID_W-1:0]  rsp_id;
  logic [WO_SZ-1:0] rsp_cnt;
  logic             rsp_clo;
  logic             rsp_all;

  logic [WO_SZ-1:0] cnt;
  logic             adv1;
  logic             adv2;

  // Requester index reached k steps after base, wrapping at N_REQ.
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return ID_W'(sum);
  endfunction

  // One global stall: S2 moves when it is empty or drained, S1 when it is empty or S2 moves.
  assign adv2 = !rsp_valid || bus.rsp_ready;
  assign adv1 = !v1 || adv2;

  // Round-robin search starting at ptr; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[wrap_idx(ptr, k)]) begin
        found = 1'b1;
        win   = wrap_idx(ptr, k);
      end
    end
  end

  assign accept        = found && adv1 && !rst;
  assign bus.req_ready = accept ? (N_REQ'(1) << win) : '0;

  leading_zero_cnt #(.WI_SZ(WI_SZ), .WO_SZ(WO_SZ)) u_lzc (
    .data (op1),
    .cnt  (cnt)
  );

  // Pointer advances past the accepted requester; S1 valid follows the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      v1  <= 1'b0;
    end else begin
      if (accept) ptr <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      if (adv1)   v1  <= accept;
    end
  end

  // S1 payload captured on accept only; its contents are qualified by v1.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; the valid bit alone decides whether they matter.
    if (accept) begin
      op1  <= bus.req_data[int'(win)*WI_SZ +: WI_SZ] ^ {WI_SZ{bus.req_clo[win]}};
      id1  <= win;
      clo1 <= bus.req_clo[win];
    end
  end

  // S2 response registers; payload only changes when a real entry arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_cnt   <= '0;
      rsp_clo   <= 1'b0;
      rsp_all   <= 1'b0;
    end else if (adv2) begin
      rsp_valid <= v1;
      if (v1) begin
        rsp_id  <= id1;
        rsp_cnt <= cnt;
        rsp_clo <= clo1;
        rsp_all <= (cnt == WO_SZ'(WI_SZ));
      end
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_cnt   = rsp_cnt;
  assign bus.rsp_clo   = rsp_clo;
  assign bus.rsp_all   = rsp_all;
  assign bus.busy      = v1 || rsp_valid;

endmodule

// File: tb/tb_lzc_share_arb.sv
// Self-checking bench for lzc_share_arb: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the shared unit.
module tb_lzc_share_arb;
  localparam int N  = 4;
  localparam int WI = 32;
  localparam int WO = $clog2(WI) + 1;
  localparam int IW = $clog2(N);

  logic clk;
  logic rst;

  lzc_share_arb_if #(.N_REQ(N), .WI_SZ(WI)) bus ();

  lzc_share_arb #(.N_REQ(N), .WI_SZ(WI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cnt;
    bit clo;
  } rsp_t;

  // Stimulus for the next cycle.
  logic [N-1:0]  tv;
  logic [N-1:0]  tclo;
  logic [WI-1:0] td [N];
  logic          trr;
  logic          trst;

  // Model: arbitration pointer, stage occupancy and in-order queue of entries.
  int   m_ptr;
  bit   m_s1;
  bit   m_s2;
  bit   post_rst;
  rsp_t q[$];

  int errors;
  int checks;
  logic [N-1:0] seen_ready;

  // Leading count straight from the definition: bits equal to the mode bit from the MSB down.
  function automatic int ref_count(input logic [WI-1:0] d, input bit clo);
    int c = 0;
    while (c < WI && d[WI-1-c] == clo) c++;
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check just after, update model at posedge.
  task automatic tick();
    bit adv1, adv2, acc;
    int w;
    logic [N-1:0] exp_ready;
    rsp_t e;
    @(negedge clk);
    rst           = trst;
    bus.req_valid = tv;
    bus.req_clo   = tclo;
    for (int i = 0; i < N; i++) bus.req_data[i*WI +: WI] = td[i];
    bus.rsp_ready = trr;
    #1;
    adv2 = !m_s2 || trr;
    adv1 = !m_s1 || adv2;
    acc  = 1'b0;
    w    = 0;
    for (int k = 0; k < N; k++) begin
      if (!acc && tv[(m_ptr + k) % N]) begin
        acc = 1'b1;
        w   = (m_ptr + k) % N;
      end
    end
    acc = acc && adv1 && !trst;
    exp_ready = acc ? (N'(1) << w) : '0;
    seen_ready = bus.req_ready;
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(m_s2));
    check("busy", 64'(bus.busy), 64'(m_s1 || m_s2));
    if (m_s2) begin
      check("rsp_id", 64'(bus.rsp_id), 64'(q[0].id));
      check("rsp_cnt", 64'(bus.rsp_cnt), 64'(q[0].cnt));
      check("rsp_clo", 64'(bus.rsp_clo), 64'(q[0].clo));
      check("rsp_all", 64'(bus.rsp_all), 64'(q[0].cnt == WI));
    end
    if (post_rst) begin
      check("rst_id", 64'(bus.rsp_id), 64'd0);
      check("rst_cnt", 64'(bus.rsp_cnt), 64'd0);
      check("rst_clo", 64'(bus.rsp_clo), 64'd0);
      check("rst_all", 64'(bus.rsp_all), 64'd0);
    end
    @(posedge clk);
    if (trst) begin
      m_ptr = 0; m_s1 = 0; m_s2 = 0; post_rst = 1;
      q.delete();
    end else begin
      post_rst = 0;
      if (m_s2 && trr) void'(q.pop_front());
      if (adv2) m_s2 = m_s1;
      if (adv1) m_s1 = acc;
      if (acc) begin
        e.id  = w;
        e.clo = tclo[w];
        e.cnt = ref_count(td[w], tclo[w]);
        q.push_back(e);
        m_ptr = (w + 1) % N;
      end
    end
  endtask

  task automatic idle(input int n);
    tv = '0;
    trr = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    errors = 0; checks = 0;
    m_ptr = 0; m_s1 = 0; m_s2 = 0; post_rst = 1;
    tv = '0; tclo = '0; trr = 1'b1; trst = 1'b1;
    for (int i = 0; i < N; i++) td[i] = '0;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_clo = '0; bus.req_data = '0; bus.rsp_ready = 1'b1;
    @(posedge clk);

    // Reset with a requester pending: no grant may leak out.
    tv = 4'b0001;
    tick(); tick();
    trst = 1'b0;

    // Single clz request: 0x0000FFFF -> 16, two cycles later.
    idle(2);
    tv = 4'b0001; tclo = '0; td[0] = 32'h0000_FFFF;
    tick();
    check("single_grant", 64'(seen_ready), 64'h1);
    idle(1);
    tick();
    check("single_cnt", 64'(bus.rsp_cnt), 64'd16);
    check("single_valid", 64'(bus.rsp_valid), 64'd1);

    // Mode and edge values through requester 1.
    begin
      logic [WI-1:0] vals [6];
      bit            mods [6];
      vals = '{32'hF000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
      mods = '{1, 0, 1, 0, 1, 0};
      for (int i = 0; i < 6; i++) begin
        tv = 4'b0010; td[1] = vals[i]; tclo = {2'b00, mods[i], 1'b0};
        tick();
      end
      idle(3);
    end

    // Fairness from a fresh pointer: grants rotate 0,1,2,3,...
    trst = 1'b1; tick(); trst = 1'b0;
    tv = 4'b1111; tclo = 4'b0101;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) td[i] = $urandom >> $urandom_range(0, 31);
      tick();
      check("fair_grant", 64'(seen_ready), 64'(4'b0001 << (k % 4)));
    end
    idle(3);

    // Pointer skip and wrap: ptr=2, requesters 1 and 3 valid -> 3, 1, 3.
    trst = 1'b1; tick(); trst = 1'b0;
    tv = 4'b0010; tick();
    tv = 4'b1010;
    tick(); check("skip_a", 64'(seen_ready), 64'b1000);
    tick(); check("skip_b", 64'(seen_ready), 64'b0010);
    tick(); check("skip_c", 64'(seen_ready), 64'b1000);
    idle(3);

    // Backpressure: stream from requester 2 with rsp_ready low for 3 cycles.
    tv = 4'b0100; tclo = 4'b0000; trr = 1'b0;
    td[2] = 32'h0001_0000; tick();
    td[2] = 32'h0000_0100; tick();
    td[2] = 32'h0000_0004; tick();
    check("bp_full", 64'(seen_ready), 64'd0);
    trr = 1'b1;
    tick();
    check("bp_release", 64'(seen_ready), 64'b0100);
    td[2] = 32'h4000_0000; tick();
    idle(3);

    // Reset mid-operation with two entries in flight.
    tv = 4'b0001; trr = 1'b0;
    td[0] = 32'h0000_00FF; tick(); tick();
    tv = 4'b1111; trst = 1'b1; tick(); trst = 1'b0;
    tv = 4'b1100; td[2] = 32'h00FF_0000; td[3] = 32'h0F00_0000; trr = 1'b1;
    tick();
    check("post_rst_grant", 64'(seen_ready), 64'b0100);
    idle(3);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      tv   = N'($urandom);
      tclo = N'($urandom);
      for (int i = 0; i < N; i++) begin
        td[i] = $urandom >> $urandom_range(0, 32);
        if ($urandom_range(0, 3) == 0) td[i] = ~td[i];
      end
      trr  = ($urandom_range(0, 3) != 0);
      trst = ($urandom_range(0, 99) == 0);
      tick();
    end
    trst = 1'b0;
    idle(4);
    check("drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
